price_word_sender: RTL
======================

// Module: price_word_sender
// PURPOSE
//  Producer side of the stock_price/data_ready interface consumed by the computation controller.
//  Assembles 32-bit prices from an incoming byte stream (MSB first) and buffers them in a small FIFO.
//  Presents each price as a one-cycle data_ready strobe. The interface has no acknowledge, so
//  consecutive strobes are spaced by a programmable gap.
// PARAMETERS
//  DEPTH       4   FIFO depth in 32-bit words (power of 2, >=2)
//  GAP_CYCLES  8   minimum idle cycles after a data_ready strobe before the next one (>=1)
// PORTS
//  clk            in   1   system clock, all logic on posedge
//  n_rst          in   1   asynchronous active-low reset
//  byte_in        in   8   incoming price byte
//  byte_valid     in   1   byte_in valid this cycle
//  frame_start    in   1   qualified by byte_valid: this byte is byte 0 (MSB) of a new price
//  send_en        in   1   1 = controller may be fed; 0 = hold words in FIFO
//  stock_price    out  32  price to controller; valid while data_ready=1, held afterwards
//  data_ready     out  1   one-cycle strobe: stock_price carries a new price
//  fifo_count     out  $clog2(DEPTH)+1  words currently buffered
//  overrun_err    out  1   one-cycle pulse: completed word dropped, FIFO full
//  framing_err    out  1   one-cycle pulse: frame_start arrived with 1-3 bytes pending
// BEHAVIOUR
//  Reset: stock_price=0, data_ready=0, fifo_count=0, overrun_err=0, framing_err=0,
//   byte counter=0, FSM=SIDLE, gap counter=0. Reset mid-word or mid-gap discards all state.
//  Assembler: shift register plus 2-bit byte counter.
//   byte_valid=1 shifts byte_in into the low byte and increments the counter.
//   frame_start=1 with counter!=0: discard partial word, pulse framing_err, treat byte as byte 0.
//   frame_start ignored when byte_valid=0. Bytes without frame_start continue the current word.
//   Fourth byte: counter wraps to 0 and the word {b0,b1,b2,b3} is pushed into the FIFO on the
//   same edge.
//  FIFO: push when full is dropped and overrun_err pulses, unless a pop occurs the same cycle.
//   A simultaneous push and pop on a full FIFO is accepted. A simultaneous push and pop on an
//   empty FIFO is impossible, because the pop requires count>0 at the start of the cycle.
//   fifo_count updates on the edge that performs the push or pop.
//  Sender FSM (enum in package):
//   SIDLE: if send_en && count>0: pop, register head into stock_price -> SSEND.
//   SSEND: data_ready=1 for exactly this cycle; load gap counter=GAP_CYCLES -> SGAP.
//   SGAP : decrement each cycle; at 1 -> SIDLE. send_en is ignored here and the gap always completes.
//  Latency: 4th byte sampled at edge E0. With the FSM idle, FIFO empty and send_en=1, the pop
//   happens at E1 and data_ready is high between E1 and E2.
//  Throughput: at most one strobe per GAP_CYCLES+2 cycles.
//  send_en=0 in SIDLE: no pop. Bytes are still assembled and buffered.
//  data_ready never asserts on consecutive cycles. stock_price changes only on the pop edge.
// STRUCTURE
//  Package price_pkg: typedef enum logic [1:0] {SIDLE, SSEND, SGAP} sendState;
//   localparam PRICE_W=32, BYTES_PER_WORD=4.
//  Sub-module price_fifo (DEPTH, PRICE_W): sync FIFO with push/pop/full/empty/count,
//   pointer wrap modulo DEPTH. Assembler and sender FSM stay in this module.
// TESTING
//  1 Reset, send_en=1, bytes 12,34,56,78 (fs on first) -> data_ready 1 cycle, price 0x12345678,
//    strobe between E1 and E2 of the 4th byte.
//  2 Three back-to-back words, GAP_CYCLES=8 -> three strobes exactly 10 cycles apart, in order.
//  3 send_en=0, push DEPTH+1 words -> fifo_count=DEPTH, one overrun_err pulse.
//    Then send_en=1 -> exactly DEPTH strobes with the first DEPTH prices.
//  4 Bytes AA,BB then fs with 01,02,03,04 -> framing_err pulse on the fs byte,
//    single strobe with 0x01020304.
//  5 Full FIFO, 4th byte completes on the SIDLE pop cycle -> no overrun, count stays DEPTH.
//  6 n_rst low during SGAP with two words queued -> all outputs 0 immediately,
//    no strobe after release until new bytes arrive.

Source files
------------

// File: rtl/price_pkg.sv
// rtl/price_pkg.sv - shared types and constants for the price word sender
package price_pkg;

    localparam int PRICE_W        = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        SIDLE,
        SSEND,
        SGAP
    } sendState;

endpackage

// File: rtl/price_fifo.sv
// rtl/price_fifo.sv - synchronous word FIFO with push/pop/full/empty/count
module price_fifo
    import price_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int WORD_W  = PRICE_W
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     push,
    input  logic [WORD_W-1:0]        push_data,
    input  logic                     pop,
    output logic [WORD_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    // A pop frees a slot in the same cycle, so a full FIFO may still accept a push then.
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage array: written on accepted pushes only, contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/price_word_sender.sv
// rtl/price_word_sender.sv - assembles byte-stream prices and strobes them out with a fixed gap
module price_word_sender
    import price_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [7:0]              byte_in,
    input  logic                    byte_valid,
    input  logic                    frame_start,
    input  logic                    send_en,
    output logic [PRICE_W-1:0]      stock_price,
    output logic                    data_ready,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    overrun_err,
    output logic                    framing_err
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    sendState             state;
    sendState             next_state;
    logic [GAP_W-1:0]     gap_cnt;
    logic [PRICE_W-9:0]   partial;
    logic [1:0]           byte_cnt;
    logic                 word_done;
    logic [PRICE_W-1:0]   word;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [PRICE_W-1:0]   fifo_head;

    // The last byte goes straight into the FIFO together with the three already shifted in.
    assign word_done = byte_valid && !frame_start && (byte_cnt == 2'(BYTES_PER_WORD - 1));
    assign word      = {partial, byte_in};

    price_fifo #(
        .DEPTH  (DEPTH),
        .WORD_W (PRICE_W)
    ) u_fifo (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (word_done),
        .push_data (word),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Byte assembler: frame_start restarts the word, flagging any partial word it discards.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            partial     <= '0;
            byte_cnt    <= '0;
            framing_err <= 1'b0;
        end else begin
            framing_err <= byte_valid && frame_start && (byte_cnt != 2'd0);
            if (byte_valid) begin
                if (frame_start) begin
                    partial  <= {{(PRICE_W-16){1'b0}}, byte_in};
                    byte_cnt <= 2'd1;
                end else begin
                    partial  <= {partial[PRICE_W-17:0], byte_in};
                    byte_cnt <= byte_cnt + 2'd1;
                end
            end
        end
    end

    // Overrun only when the completed word finds no room and nothing is leaving this cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= word_done && fifo_full && !pop;
        end
    end

    // Sender state, gap timer and output price register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= SIDLE;
            gap_cnt     <= '0;
            stock_price <= '0;
        end else begin
            state <= next_state;
            if (state == SSEND) begin
                gap_cnt <= GAP_W'(GAP_CYCLES);
            end else if (state == SGAP) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
            if (pop) begin
                stock_price <= fifo_head;
            end
        end
    end

    // Sender next-state: pop only from idle, strobe for one cycle, then sit out the gap.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        data_ready = 1'b0;
        case (state)
            SIDLE: begin
                if (send_en && !fifo_empty) begin
                    pop        = 1'b1;
                    next_state = SSEND;
                end
            end
            SSEND: begin
                data_ready = 1'b1;
                next_state = SGAP;
            end
            SGAP: begin
                if (gap_cnt == GAP_W'(1)) begin
                    next_state = SIDLE;
                end
            end
            default: next_state = SIDLE;
        endcase
    end

endmodule
